fb_stream_timing: RTL
=====================

FB_STREAM_TIMING -- requirements
Module: fb_stream_timing

Interface
REQ-001 SHALL have parameter pHRES, default 1280, active pixels per line.
REQ-002 SHALL have parameter pVRES, default 720, active lines per frame.
REQ-003 SHALL have parameters pHTOTAL/pVTOTAL, default 1354/910, total pixels per line and lines per frame.
REQ-004 SHALL have parameters pHSS/pHSE, default 1300/1340, HS start (inclusive) and end (exclusive) pixel.
REQ-005 SHALL have parameters pVSS/pVSE, default 778/782, VS start (inclusive) and end (exclusive) line.
REQ-006 SHALL have parameter pFMT, default 0, pixel format: 0=RGB555, 1=RGB565, 2=RGB888.
REQ-007 SHALL have parameter pDATA_W, default 15, iFB_DATA width: 15, 16 or 24 matching pFMT.
REQ-008 SHALL have parameters pHS_POL/pVS_POL, default 1/1, active level of oHS/oVS.
REQ-009 SHALL have ports:
 iCLK  in  1  pixel clock, rising edge
 iRESETn  in  1  asynchronous, active-low reset
 iFB_START  in  1  start-of-frame marker on current beat
 iFB_DATA  in  pDATA_W  pixel beat
 iFB_DATAVALID  in  1  beat valid
 oFB_READY  out  1  beat accepted when valid & ready
 iCLR_ERR  in  1  clears underrun flag and counter
 oRED/oGRN/oBLU  out  8 each  pixel colour
 oHS/oVS/oDE  out  1 each  sync, data enable
 oSOF  out  1  one-cycle pulse at frame origin
 oUNDERRUN  out  1  sticky underrun flag
 oUNDERRUN_CNT  out  16  saturating underrun event count

Function
REQ-010 SHALL run rHCNT 0..pHTOTAL-1 and rVCNT 0..pVTOTAL-1; rVCNT increments when rHCNT wraps; both wrap to 0.
REQ-011 SHALL define internal de = (rHCNT<pHRES)&(rVCNT<pVRES); vblank = rVCNT>=pVRES.
REQ-012 SHALL register oHS/oVS/oDE/colour: outputs reflect counter state of previous cycle (latency 1).
REQ-013 SHALL drive oHS=pHS_POL when pHSS<=rHCNT<pHSE, else inverse; oVS likewise on rVCNT with pVSS/pVSE.
REQ-014 SHALL implement states WAIT_SOF, ARMED, ACTIVE, FLUSH.
REQ-015 WAIT_SOF: oFB_READY = vblank & iFB_START; accepted START beat (data discarded) -> ARMED.
REQ-016 ARMED: oFB_READY=0; at rHCNT=pHTOTAL-1 & rVCNT=pVTOTAL-1 -> ACTIVE.
REQ-017 ACTIVE: oFB_READY = de & !iFB_START; each accepted beat becomes next output pixel.
REQ-018 ACTIVE: de & (!iFB_DATAVALID | iFB_START) SHALL be an underrun: pixel black, oUNDERRUN=1, count+1, -> FLUSH.
REQ-019 ACTIVE: beat accepted at rHCNT=pHRES-1, rVCNT=pVRES-1 -> WAIT_SOF.
REQ-020 FLUSH: oFB_READY = !iFB_START | vblank; non-START beats discarded; accepted START beat in vblank -> ARMED; START outside vblank held (ready 0).
REQ-021 SHALL output colour 0 whenever registered oDE=0 or no beat accepted for that pixel.
REQ-022 RGB555: R=d[14:10], G=d[9:5], B=d[4:0]; each 5-bit field expanded to 8 bits as {f,f[4:2]}.
REQ-023 RGB565: R=d[15:11], G=d[10:5], B=d[4:0]; 5-bit as REQ-022, 6-bit as {f,f[5:4]}.
REQ-024 RGB888: R=d[23:16], G=d[15:8], B=d[7:0] unchanged.
REQ-025 oSOF SHALL pulse 1 cycle aligned with first registered pixel of each frame (oDE rising at line 0), regardless of state.
REQ-026 oUNDERRUN_CNT SHALL saturate at 16'hFFFF.
REQ-027 iCLR_ERR same cycle as underrun SHALL yield oUNDERRUN=1, count=1.

Reset
REQ-028 iRESETn low SHALL asynchronously set rHCNT=0, rVCNT=0, state WAIT_SOF, oDE=0, colour=0, oHS=!pHS_POL, oVS=!pVS_POL, oSOF=0, oFB_READY=0, oUNDERRUN=0, count=0.
REQ-029 Reset mid-frame SHALL abandon the frame; after release streaming restarts only via REQ-015.

Verification (pHRES=4,pVRES=2,pHTOTAL=8,pVTOTAL=4,pHSS=5,pHSE=6,pVSS=2,pVSE=3)
REQ-030 Release reset, source always valid, START beat in vblank then 8 pixels 0x7FFF,0x0000,... -> oDE 4 cycles/line, 2 lines, colours FF/00 per beat, oUNDERRUN=0.
REQ-031 Drop iFB_DATAVALID at pixel 2 of line 0 -> that pixel black, oUNDERRUN=1, count=1, remaining active pixels black, next frame resumes after new START.
REQ-032 START asserted at pixel 1 of line 1 -> oFB_READY=0 that cycle, underrun counted, START accepted only once rVCNT>=2.
REQ-033 Force 65537 underruns (frames with no data) -> count=0xFFFF; iCLR_ERR pulse -> flag 0, count 0.
REQ-034 pFMT=1, beat 16'hF800 -> oRED=FF, oGRN=00, oBLU=00; pHS_POL=0 -> oHS low exactly 1 cycle per line at registered rHCNT=5.
REQ-035 Assert iRESETn=0 mid-line -> all outputs at REQ-028 values same cycle, no clock required.

Source files
------------

// File: rtl/fb_stream_timing.sv
// Raster timing generator that paces a valid/ready pixel stream onto RGB + HS/VS/DE outputs.
// Video outputs are registered one cycle behind the counters; an underrun blanks the rest of the frame.
module fb_stream_timing #(
  parameter int          pHRES    = 1280,
  parameter int          pVRES    = 720,
  parameter int          pHTOTAL  = 1354,
  parameter int          pVTOTAL  = 910,
  parameter int          pHSS     = 1300,
  parameter int          pHSE     = 1340,
  parameter int          pVSS     = 778,
  parameter int          pVSE     = 782,
  parameter int          pFMT     = 0,
  parameter int          pDATA_W  = 15,
  parameter int          pHS_POL  = 1,
  parameter int          pVS_POL  = 1,
  parameter logic [15:0] pCNT_SAT = 16'hFFFF
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic               iFB_START,
  input  logic [pDATA_W-1:0] iFB_DATA,
  input  logic               iFB_DATAVALID,
  output logic               oFB_READY,
  input  logic               iCLR_ERR,
  output logic [7:0]         oRED,
  output logic [7:0]         oGRN,
  output logic [7:0]         oBLU,
  output logic               oHS,
  output logic               oVS,
  output logic               oDE,
  output logic               oSOF,
  output logic               oUNDERRUN,
  output logic [15:0]        oUNDERRUN_CNT
);

  // One spare bit so exclusive sync ends equal to the total still fit.
  localparam int HW = $clog2(pHTOTAL + 1);
  localparam int VW = $clog2(pVTOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(pHTOTAL - 1);
  localparam logic [HW-1:0] H_RES  = HW'(pHRES);
  localparam logic [HW-1:0] H_LPIX = HW'(pHRES - 1);
  localparam logic [HW-1:0] H_SS   = HW'(pHSS);
  localparam logic [HW-1:0] H_SE   = HW'(pHSE);
  localparam logic [VW-1:0] V_LAST = VW'(pVTOTAL - 1);
  localparam logic [VW-1:0] V_RES  = VW'(pVRES);
  localparam logic [VW-1:0] V_LPIX = VW'(pVRES - 1);
  localparam logic [VW-1:0] V_SS   = VW'(pVSS);
  localparam logic [VW-1:0] V_SE   = VW'(pVSE);
  localparam logic          HS_ON  = 1'(pHS_POL);
  localparam logic          VS_ON  = 1'(pVS_POL);

  typedef enum logic [1:0] {
    S_WAIT_SOF,
    S_ARMED,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            h_wrap, v_wrap, de, vblank;
  logic            fb_rdy, pix_load, underrun;
  logic [23:0]     dat_ext, rgb_d, rgb_q;
  logic            de_q, hs_q, vs_q, sof_q;
  logic            err_q, err_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  function automatic logic [7:0] x5(input logic [4:0] f);
    return {f, f[4:2]};
  endfunction

  function automatic logic [7:0] x6(input logic [5:0] f);
    return {f, f[5:4]};
  endfunction

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  assign de     = (h_cnt_q < H_RES) && (v_cnt_q < V_RES);
  assign vblank = (v_cnt_q >= V_RES);

  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    fb_rdy   = 1'b0;
    pix_load = 1'b0;
    underrun = 1'b0;
    case (state_q)
      S_WAIT_SOF: begin
        fb_rdy = vblank & iFB_START;
        if (fb_rdy && iFB_DATAVALID) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (h_wrap && v_wrap) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        fb_rdy = de & ~iFB_START;
        // A START inside the active area counts as missing data for this pixel.
        if (de && (!iFB_DATAVALID || iFB_START)) begin
          underrun = 1'b1;
          state_d  = S_FLUSH;
        end else if (fb_rdy && iFB_DATAVALID) begin
          pix_load = 1'b1;
          if (h_cnt_q == H_LPIX && v_cnt_q == V_LPIX) state_d = S_WAIT_SOF;
        end
      end
      S_FLUSH: begin
        fb_rdy = ~iFB_START | vblank;
        if (fb_rdy && iFB_DATAVALID && iFB_START) state_d = S_ARMED;
      end
      default: state_d = S_WAIT_SOF;
    endcase
  end

  always_comb begin
    dat_ext = 24'(iFB_DATA);
    case (pFMT)
      1:       rgb_d = {x5(dat_ext[15:11]), x6(dat_ext[10:5]), x5(dat_ext[4:0])};
      2:       rgb_d = dat_ext;
      default: rgb_d = {x5(dat_ext[14:10]), x5(dat_ext[9:5]), x5(dat_ext[4:0])};
    endcase
  end

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (underrun) begin
      err_d     = 1'b1;
      err_cnt_d = iCLR_ERR ? 16'd1 :
                  (err_cnt_q == pCNT_SAT) ? err_cnt_q : err_cnt_q + 16'd1;
    end else if (iCLR_ERR) begin
      err_d     = 1'b0;
      err_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      state_q   <= S_WAIT_SOF;
      de_q      <= 1'b0;
      hs_q      <= ~HS_ON;
      vs_q      <= ~VS_ON;
      sof_q     <= 1'b0;
      rgb_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      state_q   <= state_d;
      de_q      <= de;
      hs_q      <= (h_cnt_q >= H_SS && h_cnt_q < H_SE) ? HS_ON : ~HS_ON;
      vs_q      <= (v_cnt_q >= V_SS && v_cnt_q < V_SE) ? VS_ON : ~VS_ON;
      sof_q     <= (h_cnt_q == '0) && (v_cnt_q == '0);
      rgb_q     <= pix_load ? rgb_d : '0;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign oFB_READY     = fb_rdy;
  assign oRED          = rgb_q[23:16];
  assign oGRN          = rgb_q[15:8];
  assign oBLU          = rgb_q[7:0];
  assign oHS           = hs_q;
  assign oVS           = vs_q;
  assign oDE           = de_q;
  assign oSOF          = sof_q;
  assign oUNDERRUN     = err_q;
  assign oUNDERRUN_CNT = err_cnt_q;

endmodule
